bigint_ram_reader: RTL and testbench
====================================

Name: bigint_ram_reader

Overview:
- Word-serial operand fetch stage that sits directly downstream of the single_port_ram operand stores in paillier_top (n, g, r, u, ...).
- On a start pulse, reads one K-bit big integer, stored least-significant word first, as NUM_WORDS consecutive RAM words.
- Presents the words on a valid/ready stream to the modular arithmetic datapath.
- Absorbs consumer backpressure and the 1-cycle RAM read latency with a 2-entry skid FIFO, so RAM reads never stall mid-cycle.

Parameters:
- K, 2048, operand width in bits.
- WIDTH_DATA, 64, RAM and stream word width.
- ADDR_W, 11, RAM address width.
- NUM_WORDS, K/WIDTH_DATA (32), words per operand; must be ≥1 and ≤2^ADDR_W.

Ports:
- clk  in  1  clock; everything is on the rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- base_addr  in  ADDR_W  RAM address of word 0; captured on accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the final word handshake.
- ram_addr  out  ADDR_W  RAM read address.
- ram_wen  out  1  constant 0; this block never writes.
- ram_rd_data  in  WIDTH_DATA  RAM read data, valid one cycle after ram_addr.
- m_data  out  WIDTH_DATA  stream word.
- m_valid  out  1  stream valid.
- m_ready  in  1  consumer ready.
- m_last  out  1  high with word NUM_WORDS-1.
- m_idx  out  $clog2(NUM_WORDS)  index of the current m_data word.

Behaviour:
- Reset: every output is 0; FIFO empty; all counters 0; state IDLE. Reset mid-operation aborts immediately; in-flight RAM data is discarded and no done pulse is produced.
- States:
  - IDLE: start=1 → capture base_addr, go to FETCH, busy=1 next cycle.
  - FETCH: issue reads.
    - A read is issued in a cycle iff issued_cnt<NUM_WORDS and (fifo_count + inflight − pop_this_cycle) < 2, where inflight means a read was issued last cycle.
    - ram_addr = base + issued_cnt, modulo 2^ADDR_W; wrap from 0x7FF to 0x000 is legal.
    - ram_addr holds its last value when no read is issued.
    - After the final read is issued → DRAIN.
  - DRAIN: wait until the FIFO is empty and nothing is in flight, with the last word handshaken → DONE.
  - DONE: done=1 and busy=0 for one cycle → IDLE.
- A start arriving while busy, or during the DONE cycle, is ignored.
- Read latency: rd_data is pushed into the FIFO the cycle after the read is issued. Back-to-back with m_ready=1, the first word reaches m_valid 2 cycles after start and the stream sustains 1 word/cycle.
- FIFO:
  - 2 entries, registered output; m_data, m_idx and m_last come from the head entry.
  - Simultaneous push and pop when full is allowed and the count stays 2.
  - Overflow is impossible by the credit rule; an assertion checks it.
- Handshake:
  - Transfer occurs when m_valid & m_ready.
  - While m_valid=1 and m_ready=0, m_data, m_idx and m_last are held stable.
  - m_valid never drops without a transfer, except on rst.
- m_idx counts 0..NUM_WORDS-1. m_last = (m_idx == NUM_WORDS-1).
- done rises the cycle after the m_last transfer, or later if the DRAIN condition is met later.
- NUM_WORDS=1: a single word has m_last=1 on its only beat.

Decomposition:
- Package paillier_pkg holds:
  - K, WIDTH_DATA, ADDR_W, NUM_WORDS;
  - the rd_state_t enum {IDLE, FETCH, DRAIN, DONE};
  - the word_t typedef, logic[WIDTH_DATA-1:0].
- One sub-module, skid_fifo2: a 2-deep, parameterised-width FIFO with push, pop, full, empty and count. It is reused by the future writer stage.

Test Plan:
- Fill RAM with addr i = 64'hA5A5_0000_0000_0000 + i, then apply start with base=0x010 and m_ready=1. Expected: 32 beats on consecutive cycles with data = …+0x10…+0x2F, m_idx 0..31, m_last only on beat 31, and done one cycle later.
- Same setup with m_ready toggled 1,0,0,1 repeatedly. Expected: all 32 words arrive in order with no drops or duplicates, data stays stable while stalled, and ram_addr never advances more than 2 words ahead of the last pop.
- Base=0x7F0. Expected: ram_addr sequence 0x7F0..0x7FF, then 0x000..0x00F, with words matching those addresses.
- Pulse start again while busy at beat 5. Expected: ignored, exactly 32 beats, one done pulse.
- Assert rst at beat 10 with m_ready=0. Expected: the next cycle shows m_valid=0, busy=0, done=0, and ram_addr=0. A fresh start then delivers words 0..31 correctly.
- With m_ready=0 throughout after start: exactly 2 reads are issued, m_valid holds with m_idx=0, and no further reads occur until m_ready=1.

Source files
------------

// File: rtl/paillier_pkg.sv
// Shared sizing, state encoding and beat payload for the Paillier operand datapath.
package paillier_pkg;

  localparam int unsigned K          = 2048;
  localparam int unsigned WIDTH_DATA = 64;
  localparam int unsigned ADDR_W     = 11;
  localparam int unsigned NUM_WORDS  = K / WIDTH_DATA;
  // Index field stays at least one bit wide so single-word operands still synthesise.
  localparam int unsigned IDX_W      = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int unsigned CNT_W      = $clog2(NUM_WORDS + 1);

  typedef logic [WIDTH_DATA-1:0] word_t;
  typedef logic [IDX_W-1:0]      idx_t;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} rd_state_t;

  typedef struct packed {
    word_t data;
    idx_t  idx;
    logic  last;
  } beat_t;

endpackage

// File: rtl/bigint_ram_reader_if.sv
// Valid/ready word stream carrying one big-integer operand, LS word first.
interface bigint_ram_reader_if;
  import paillier_pkg::*;

  word_t m_data;
  logic  m_valid;
  logic  m_ready;
  logic  m_last;
  idx_t  m_idx;

  modport master (output m_data, m_valid, m_last, m_idx, input m_ready);
  modport slave  (input m_data, m_valid, m_last, m_idx, output m_ready);
endinterface

// File: rtl/bigint_ram_reader_skid_fifo2.sv
// Two-entry FIFO with a registered head; push and pop may coincide even when full.
module skid_fifo2 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic [1:0]       count_q, count_d;
  logic             do_pop;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    do_pop  = pop && (count_q != 2'd0);
    unique case ({push, do_pop})
      2'b10: begin
        if (count_q == 2'd0) begin
          head_d  = din;
          count_d = 2'd1;
        end else if (count_q == 2'd1) begin
          tail_d  = din;
          count_d = 2'd2;
        end
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        // Occupancy is unchanged; only the entry order shifts.
        if (count_q == 2'd1) begin
          head_d = din;
        end else begin
          head_d = tail_q;
          tail_d = din;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign dout  = head_q;
  assign full  = (count_q == 2'd2);
  assign empty = (count_q == 2'd0);
  assign count = count_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && !pop && count_q == 2'd2));

endmodule

// File: rtl/bigint_ram_reader.sv
// Streams one NUM_WORDS-word operand out of a 1-cycle-latency RAM, LS word first,
// with credit-limited reads so the 2-entry skid FIFO can never overflow.
module bigint_ram_reader
  import paillier_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic                ram_wen,
  input  word_t               ram_rd_data,
  bigint_ram_reader_if.master m
);

  rd_state_t          state_q, state_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [CNT_W-1:0]   issued_q, issued_d;
  logic               inflight_q, inflight_d;
  idx_t               infl_idx_q, infl_idx_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               issue;
  idx_t               issue_idx;
  logic               m_valid_c;
  logic               pop;
  logic               credit_ok;
  beat_t              push_beat;
  beat_t              head_beat;
  logic               fifo_full;
  logic               fifo_empty;
  logic [1:0]         fifo_count;

  assign m_valid_c = !fifo_empty;
  assign pop       = m_valid_c && m.m_ready;
  // Room for one more read: fifo_count + inflight - pop < 2, written in flag form.
  assign credit_ok = fifo_empty ? 1'b1
                   : fifo_full  ? (pop && !inflight_q)
                   :              (pop || !inflight_q);

  assign push_beat = '{data: ram_rd_data,
                       idx:  infl_idx_q,
                       last: (infl_idx_q == idx_t'(NUM_WORDS - 1))};

  skid_fifo2 #(.WIDTH($bits(beat_t))) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight_q),
    .din   (push_beat),
    .pop   (pop),
    .dout  (head_beat),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Next-state and read-issue logic; word 0 is read in the accepting cycle to save a beat of latency.
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    addr_d    = addr_q;
    issued_d  = issued_q;
    issue     = 1'b0;
    issue_idx = idx_t'(issued_q);
    unique case (state_q)
      IDLE: begin
        if (start) begin
          base_d    = base_addr;
          addr_d    = base_addr;
          issue     = 1'b1;
          issue_idx = '0;
          issued_d  = CNT_W'(1);
          state_d   = (NUM_WORDS == 1) ? DRAIN : FETCH;
        end
      end
      FETCH: begin
        if (credit_ok && (issued_q < CNT_W'(NUM_WORDS))) begin
          issue    = 1'b1;
          addr_d   = base_q + ADDR_W'(issued_q);
          issued_d = issued_q + CNT_W'(1);
          if (issued_q == CNT_W'(NUM_WORDS - 1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!inflight_q && (fifo_count == {1'b0, pop})) state_d = DONE;
      end
      DONE: begin
        state_d  = IDLE;
        issued_d = '0;
      end
      default: state_d = IDLE;
    endcase
    inflight_d = issue;
    infl_idx_d = issue_idx;
    busy_d     = (state_d == FETCH) || (state_d == DRAIN);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      base_q     <= '0;
      addr_q     <= '0;
      issued_q   <= '0;
      inflight_q <= 1'b0;
      infl_idx_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      addr_q     <= addr_d;
      issued_q   <= issued_d;
      inflight_q <= inflight_d;
      infl_idx_q <= infl_idx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign ram_addr  = addr_d;
  assign ram_wen   = 1'b0;
  assign busy      = busy_q;
  assign done      = done_q;
  assign m.m_valid = m_valid_c;
  assign m.m_data  = head_beat.data;
  assign m.m_idx   = head_beat.idx;
  assign m.m_last  = head_beat.last;

endmodule

// File: tb/tb_bigint_ram_reader.sv
// Randomised self-checking bench: a RAM array model plus expected beats derived from base+k.
module tb_bigint_ram_reader;
  import paillier_pkg::*;

  localparam int NW        = int'(NUM_WORDS);
  localparam int DEPTH     = 1 << ADDR_W;
  localparam int STALL_CYC = 20;
  localparam int BUDGET    = 600;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_wen;
  word_t             ram_rd_data;

  bigint_ram_reader_if mif ();

  bigint_ram_reader dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .base_addr   (base_addr),
    .busy        (busy),
    .done        (done),
    .ram_addr    (ram_addr),
    .ram_wen     (ram_wen),
    .ram_rd_data (ram_rd_data),
    .m           (mif)
  );

  always #5 clk = ~clk;

  word_t mem [DEPTH];
  always @(posedge clk) ram_rd_data <= mem[ram_addr];

  int n_checks = 0;
  int n_fail   = 0;

  // Observations gathered by run_op for the calling test to judge.
  word_t             ob_data[$];
  int                ob_idx[$];
  bit                ob_last[$];
  int                ob_cyc[$];
  logic [ADDR_W-1:0] ob_addr[$];
  int                ob_done[$];
  int ob_busy_cnt, ob_busy_at_done, ob_unstable, ob_drop, ob_max_ahead;
  int ob_first_valid, ob_snap_issues, ob_snap_valid, ob_snap_idx, ob_wen_hi;
  bit ob_timeout;

  function automatic word_t exp_word(input logic [ADDR_W-1:0] base, input int k);
    logic [ADDR_W-1:0] a;
    a = base + ADDR_W'(k);
    return mem[a];
  endfunction

  function automatic logic [ADDR_W-1:0] exp_addr(input logic [ADDR_W-1:0] base, input int k);
    return base + ADDR_W'(k);
  endfunction

  task automatic fill_pattern();
    for (int i = 0; i < DEPTH; i++) mem[i] = 64'hA5A5_0000_0000_0000 + word_t'(i);
  endtask

  // Drives one operand fetch and records what the DUT does, cycle by cycle.
  task automatic run_op(input logic [ADDR_W-1:0] base, input int mode, input int restart_beat);
    int cyc, tail, ahead;
    bit rs_done, prev_v, prev_r, prev_l;
    word_t prev_d;
    int prev_i;
    logic [ADDR_W-1:0] prev_a;
    ob_data.delete(); ob_idx.delete(); ob_last.delete(); ob_cyc.delete();
    ob_addr.delete(); ob_done.delete();
    ob_busy_cnt = 0; ob_busy_at_done = 0; ob_unstable = 0; ob_drop = 0; ob_max_ahead = 0;
    ob_first_valid = -1; ob_snap_issues = -1; ob_snap_valid = -1; ob_snap_idx = -1; ob_wen_hi = 0;
    ob_timeout = 1'b1; tail = -1; rs_done = 1'b0; prev_v = 1'b0; prev_r = 1'b0;
    prev_d = '0; prev_i = 0; prev_l = 1'b0; prev_a = '0;
    for (cyc = 0; cyc < BUDGET; cyc++) begin
      @(negedge clk);
      start     = (cyc == 0);
      base_addr = base;
      if (restart_beat >= 0 && !rs_done && ob_data.size() == restart_beat) begin
        start = 1'b1; base_addr = ~base; rs_done = 1'b1;
      end
      case (mode)
        0:       mif.m_ready = 1'b1;
        1:       mif.m_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        2:       mif.m_ready = 1'($urandom_range(0, 1));
        default: mif.m_ready = (cyc >= STALL_CYC);
      endcase
      #1;
      if (cyc == 0 || ram_addr !== prev_a) ob_addr.push_back(ram_addr);
      prev_a = ram_addr;
      if (prev_v && !prev_r) begin
        if (!mif.m_valid) ob_drop++;
        else if (mif.m_data !== prev_d || int'(mif.m_idx) != prev_i || mif.m_last !== prev_l) ob_unstable++;
      end
      if (mif.m_valid && ob_first_valid < 0) ob_first_valid = cyc;
      if (mif.m_valid && mif.m_ready) begin
        ob_data.push_back(mif.m_data); ob_idx.push_back(int'(mif.m_idx));
        ob_last.push_back(mif.m_last); ob_cyc.push_back(cyc);
      end
      if (busy) ob_busy_cnt++;
      if (ram_wen) ob_wen_hi++;
      if (done) begin
        ob_done.push_back(cyc);
        if (busy) ob_busy_at_done++;
        if (tail < 0) tail = cyc + 4;
      end
      ahead = ob_addr.size() - ob_data.size();
      if (ahead > ob_max_ahead) ob_max_ahead = ahead;
      if (cyc == STALL_CYC - 1) begin
        ob_snap_issues = ob_addr.size(); ob_snap_valid = int'(mif.m_valid); ob_snap_idx = int'(mif.m_idx);
      end
      prev_v = mif.m_valid; prev_r = mif.m_ready; prev_d = mif.m_data;
      prev_i = int'(mif.m_idx); prev_l = mif.m_last;
      if (cyc == tail) begin
        ob_timeout = 1'b0;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; base_addr = '0; mif.m_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL reset_busy_done: got %b, want 00", {busy, done}); end
    n_checks++; if ({mif.m_valid, mif.m_last} !== 2'b00) begin n_fail++; $display("FAIL reset_valid_last: got %b, want 00", {mif.m_valid, mif.m_last}); end
    n_checks++; if (mif.m_data !== '0 || mif.m_idx !== '0) begin n_fail++; $display("FAIL reset_data_idx: got %h/%0d, want 0/0", mif.m_data, mif.m_idx); end
    n_checks++; if (ram_addr !== '0 || ram_wen !== 1'b0) begin n_fail++; $display("FAIL reset_ram: addr=%h wen=%b, want 0/0", ram_addr, ram_wen); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [ADDR_W-1:0] base = 11'h010;
    int last_cyc;
    run_op(base, 0, -1);
    n_checks++; if (ob_timeout) begin n_fail++; $display("FAIL b2b_timeout: no done within %0d cycles", BUDGET); end
    n_checks++; if (ob_data.size() != NW) begin n_fail++; $display("FAIL b2b_beats: got %0d, want %0d", ob_data.size(), NW); end
    for (int k = 0; k < ob_data.size() && k < NW; k++) begin
      n_checks++;
      if (ob_data[k] !== exp_word(base, k) || ob_idx[k] != k || ob_last[k] !== (k == NW - 1) || ob_cyc[k] != 2 + k) begin
        n_fail++;
        $display("FAIL b2b_beat%0d: data=%h idx=%0d last=%b cyc=%0d, want %h %0d %b %0d",
                 k, ob_data[k], ob_idx[k], ob_last[k], ob_cyc[k], exp_word(base, k), k, (k == NW - 1), 2 + k);
      end
    end
    last_cyc = (ob_cyc.size() > 0) ? ob_cyc[ob_cyc.size() - 1] : -100;
    n_checks++; if (ob_done.size() != 1 || ob_done[0] != last_cyc + 1) begin n_fail++; $display("FAIL b2b_done: %0d pulses first at %0d, want 1 at %0d", ob_done.size(), (ob_done.size() > 0) ? ob_done[0] : -1, last_cyc + 1); end
    n_checks++; if (ob_busy_cnt != NW + 1 || ob_busy_at_done != 0) begin n_fail++; $display("FAIL b2b_busy: cycles=%0d at_done=%0d, want %0d/0", ob_busy_cnt, ob_busy_at_done, NW + 1); end
    n_checks++; if (ob_first_valid != 2) begin n_fail++; $display("FAIL b2b_latency: first valid cycle %0d, want 2", ob_first_valid); end
    n_checks++; if (ob_wen_hi != 0) begin n_fail++; $display("FAIL b2b_wen: %0d cycles with ram_wen=1, want 0", ob_wen_hi); end
  endtask

  task automatic test_backpressure();
    logic [ADDR_W-1:0] base = 11'h010;
    int last_cyc;
    run_op(base, 1, -1);
    n_checks++; if (ob_timeout || ob_data.size() != NW) begin n_fail++; $display("FAIL bp_beats: got %0d timeout=%0d, want %0d", ob_data.size(), ob_timeout, NW); end
    for (int k = 0; k < ob_data.size() && k < NW; k++) begin
      n_checks++;
      if (ob_data[k] !== exp_word(base, k) || ob_idx[k] != k || ob_last[k] !== (k == NW - 1)) begin
        n_fail++; $display("FAIL bp_beat%0d: data=%h idx=%0d last=%b, want %h %0d %b", k, ob_data[k], ob_idx[k], ob_last[k], exp_word(base, k), k, (k == NW - 1));
      end
    end
    n_checks++; if (ob_unstable != 0 || ob_drop != 0) begin n_fail++; $display("FAIL bp_hold: unstable=%0d dropped=%0d, want 0/0", ob_unstable, ob_drop); end
    n_checks++; if (ob_max_ahead > 2) begin n_fail++; $display("FAIL bp_lookahead: reads ahead of pops %0d, want <=2", ob_max_ahead); end
    last_cyc = (ob_cyc.size() > 0) ? ob_cyc[ob_cyc.size() - 1] : -100;
    n_checks++; if (ob_done.size() != 1 || ob_done[0] != last_cyc + 1) begin n_fail++; $display("FAIL bp_done: %0d pulses, want 1 at %0d", ob_done.size(), last_cyc + 1); end
  endtask

  task automatic test_wrap();
    logic [ADDR_W-1:0] base = 11'h7F0;
    n_checks++; if (ob_timeout == 1'b0 && 0) ;
    run_op(base, 0, -1);
    n_checks++; if (ob_addr.size() != NW) begin n_fail++; $display("FAIL wrap_naddr: got %0d reads, want %0d", ob_addr.size(), NW); end
    for (int k = 0; k < ob_addr.size() && k < NW; k++) begin
      n_checks++; if (ob_addr[k] !== exp_addr(base, k)) begin n_fail++; $display("FAIL wrap_addr%0d: got %h, want %h", k, ob_addr[k], exp_addr(base, k)); end
    end
    for (int k = 0; k < ob_data.size() && k < NW; k++) begin
      n_checks++; if (ob_data[k] !== exp_word(base, k) || ob_idx[k] != k) begin n_fail++; $display("FAIL wrap_beat%0d: data=%h idx=%0d, want %h %0d", k, ob_data[k], ob_idx[k], exp_word(base, k), k); end
    end
  endtask

  task automatic test_start_while_busy();
    logic [ADDR_W-1:0] base = 11'h010;
    run_op(base, 0, 5);
    n_checks++; if (ob_data.size() != NW || ob_timeout) begin n_fail++; $display("FAIL restart_beats: got %0d timeout=%0d, want %0d", ob_data.size(), ob_timeout, NW); end
    for (int k = 0; k < ob_data.size() && k < NW; k++) begin
      n_checks++; if (ob_data[k] !== exp_word(base, k) || ob_idx[k] != k) begin n_fail++; $display("FAIL restart_beat%0d: data=%h idx=%0d, want %h %0d", k, ob_data[k], ob_idx[k], exp_word(base, k), k); end
    end
    n_checks++; if (ob_done.size() != 1) begin n_fail++; $display("FAIL restart_done: got %0d done pulses, want 1", ob_done.size()); end
  endtask

  task automatic test_reset_mid_op();
    int pops = 0;
    int noise = 0;
    bit hit = 1'b0;
    @(negedge clk); start = 1'b1; base_addr = 11'h010; mif.m_ready = 1'b1;
    for (int c = 0; c < 200; c++) begin
      #1;
      if (mif.m_valid && mif.m_ready) pops++;
      @(negedge clk);
      start = 1'b0;
      if (pops == 10) begin hit = 1'b1; break; end
    end
    n_checks++; if (!hit) begin n_fail++; $display("FAIL rstmid_reach: only %0d beats before budget, want 10", pops); end
    mif.m_ready = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    #1;
    n_checks++; if ({mif.m_valid, busy, done} !== 3'b000) begin n_fail++; $display("FAIL rstmid_flags: valid/busy/done=%b, want 000", {mif.m_valid, busy, done}); end
    n_checks++; if (ram_addr !== '0 || mif.m_idx !== '0) begin n_fail++; $display("FAIL rstmid_addr: addr=%h idx=%0d, want 0/0", ram_addr, mif.m_idx); end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); #1;
      if (done || mif.m_valid || busy) noise++;
    end
    n_checks++; if (noise != 0) begin n_fail++; $display("FAIL rstmid_quiet: %0d cycles of activity after reset, want 0", noise); end
    run_op(11'h010, 0, -1);
    n_checks++; if (ob_data.size() != NW || ob_done.size() != 1) begin n_fail++; $display("FAIL rstmid_refetch: beats=%0d done=%0d, want %0d/1", ob_data.size(), ob_done.size(), NW); end
    for (int k = 0; k < ob_data.size() && k < NW; k++) begin
      n_checks++; if (ob_data[k] !== exp_word(11'h010, k) || ob_idx[k] != k) begin n_fail++; $display("FAIL rstmid_beat%0d: data=%h idx=%0d, want %h %0d", k, ob_data[k], ob_idx[k], exp_word(11'h010, k), k); end
    end
  endtask

  task automatic test_stall();
    logic [ADDR_W-1:0] base = 11'h123;
    run_op(base, 3, -1);
    n_checks++; if (ob_snap_issues != 2) begin n_fail++; $display("FAIL stall_reads: %0d reads while stalled, want 2", ob_snap_issues); end
    n_checks++; if (ob_snap_valid != 1 || ob_snap_idx != 0) begin n_fail++; $display("FAIL stall_head: valid=%0d idx=%0d, want 1/0", ob_snap_valid, ob_snap_idx); end
    n_checks++; if (ob_data.size() != NW || ob_unstable != 0 || ob_drop != 0) begin n_fail++; $display("FAIL stall_resume: beats=%0d unstable=%0d drop=%0d, want %0d/0/0", ob_data.size(), ob_unstable, ob_drop, NW); end
    for (int k = 0; k < ob_data.size() && k < NW; k++) begin
      n_checks++; if (ob_data[k] !== exp_word(base, k)) begin n_fail++; $display("FAIL stall_beat%0d: got %h, want %h", k, ob_data[k], exp_word(base, k)); end
    end
  endtask

  task automatic test_random();
    logic [ADDR_W-1:0] base;
    for (int i = 0; i < DEPTH; i++) mem[i] = {$urandom, $urandom};
    for (int it = 0; it < 4; it++) begin
      base = ADDR_W'($urandom);
      run_op(base, 2, -1);
      n_checks++; if (ob_timeout || ob_data.size() != NW || ob_done.size() != 1) begin n_fail++; $display("FAIL rand%0d_shape: beats=%0d done=%0d timeout=%0d", it, ob_data.size(), ob_done.size(), ob_timeout); end
      for (int k = 0; k < ob_data.size() && k < NW; k++) begin
        n_checks++;
        if (ob_data[k] !== exp_word(base, k) || ob_idx[k] != k || ob_last[k] !== (k == NW - 1)) begin
          n_fail++; $display("FAIL rand%0d_beat%0d: data=%h idx=%0d last=%b, want %h %0d %b", it, k, ob_data[k], ob_idx[k], ob_last[k], exp_word(base, k), k, (k == NW - 1));
        end
      end
      n_checks++; if (ob_unstable != 0 || ob_drop != 0 || ob_max_ahead > 2) begin n_fail++; $display("FAIL rand%0d_flow: unstable=%0d drop=%0d ahead=%0d", it, ob_unstable, ob_drop, ob_max_ahead); end
    end
  endtask

  initial begin
    fill_pattern();
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_wrap();
    test_start_while_busy();
    test_stall();
    test_reset_mid_op();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
